// File: rtl/multi_stage_database_loader_pkg.sv
// rtl/multi_stage_database_loader_pkg.sv - shared state encoding and sizing helpers
package multi_stage_database_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SWAP  = 2'd3
  } state_t;

  function automatic int clog2_min1(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

  function automatic int calc_num_entries(input int nc, input int np, input int nt);
    return nc * np + nt;
  endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - wrapping index counter, end_count flags the last enabled step
module counter
  import multi_stage_database_loader_pkg::*;
#(
  parameter int MAX_SIZE = 8,
  localparam int CW = clog2_min1(MAX_SIZE)
) (
  input  logic          clk_fpga,
  input  logic          reset_fpga,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          end_count
);

  logic [CW-1:0] count_q, count_d;

  assign end_count = enable && (count_q == CW'(MAX_SIZE - 1));
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = end_count ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stage_rom_sync.sv
// rtl/stage_rom_sync.sv - stage ROM image with one-cycle registered read
module stage_rom_sync #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter     FILE_STAGE_MEM = "memory.mif"
) (
  input  logic                  clk_fpga,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  initial begin
    for (int a = 0; a < 2**ADDR_WIDTH; a++) begin
      mem[a] = DATA_WIDTH'(16'h0100) + DATA_WIDTH'(a);
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (ren) data <= mem[addr];
  end

endmodule

// File: rtl/multi_stage_database_loader.sv
// rtl/multi_stage_database_loader.sv - double-buffered stage database loaded from the stage ROM
module multi_stage_database_loader
  import multi_stage_database_loader_pkg::*;
#(
  parameter int ADDR_WIDTH               = 12,
  parameter int DATA_WIDTH               = 16,
  parameter int NUM_STAGES               = 4,
  parameter int NUM_CLASSIFIERS          = 10,
  parameter int NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int NUM_STAGE_THRESHOLD      = 3,
  parameter     FILE_STAGE_MEM           = "memory.mif",
  localparam int NUM_ENTRIES = calc_num_entries(NUM_CLASSIFIERS, NUM_PARAM_PER_CLASSIFIER,
                                                NUM_STAGE_THRESHOLD),
  localparam int STAGE_WIDTH = clog2_min1(NUM_STAGES),
  localparam int ROM_WIDTH   = NUM_ENTRIES * DATA_WIDTH
) (
  input  logic                   clk_fpga,
  input  logic                   reset_fpga,
  input  logic                   i_load,
  input  logic [STAGE_WIDTH-1:0] i_stage,
  input  logic                   i_abort,
  output logic                   o_busy,
  output logic                   o_ready,
  output logic                   o_done,
  output logic                   o_error,
  output logic [STAGE_WIDTH-1:0] o_stage,
  output logic [ROM_WIDTH-1:0]   o_rom
);

  localparam int IW = clog2_min1(NUM_ENTRIES);

  state_t                 state_q, state_d;
  logic [STAGE_WIDTH-1:0] stage_q, stage_d, act_stage_q;
  logic                   bank_sel_q;
  logic [1:0][ROM_WIDTH-1:0] bank_q;
  logic                   wr_en_q;
  logic [IW-1:0]          wr_idx_q;
  logic                   busy_q, ready_q, done_q, error_q;
  logic                   req_err;
  logic                   load_ok, stage_ok, fetch_en, end_count;
  logic [IW-1:0]          idx;
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic [DATA_WIDTH-1:0]  rom_data;

  assign load_ok  = i_load && !i_abort;
  assign stage_ok = 32'(i_stage) < NUM_STAGES;
  assign fetch_en = (state_q == ST_FETCH) && !i_abort;
  assign rom_addr = ADDR_WIDTH'(stage_q) * ADDR_WIDTH'(NUM_ENTRIES) + ADDR_WIDTH'(idx);

  counter #(.MAX_SIZE(NUM_ENTRIES)) u_idx (
    .clk_fpga  (clk_fpga),
    .reset_fpga(reset_fpga),
    .clear     (i_abort),
    .enable    (fetch_en),
    .count     (idx),
    .end_count (end_count)
  );

  stage_rom_sync #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .FILE_STAGE_MEM(FILE_STAGE_MEM)
  ) u_rom (
    .clk_fpga(clk_fpga),
    .ren     (state_q == ST_FETCH),
    .addr    (rom_addr),
    .data    (rom_data)
  );

  // SWAP also accepts a request so back-to-back loads lose no cycle.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    req_err = 1'b0;
    case (state_q)
      ST_IDLE, ST_SWAP: begin
        state_d = ST_IDLE;
        if (load_ok) begin
          if (stage_ok) begin
            state_d = ST_FETCH;
            stage_d = i_stage;
          end else begin
            req_err = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (i_abort)        state_d = ST_IDLE;
        else if (end_count) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = i_abort ? ST_IDLE : ST_SWAP;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      act_stage_q <= '0;
      bank_sel_q  <= 1'b0;
      bank_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      busy_q   <= (state_d != ST_IDLE);
      error_q  <= req_err;
      done_q   <= (state_q == ST_SWAP);
      wr_en_q  <= fetch_en;
      wr_idx_q <= idx;
      if (wr_en_q) bank_q[~bank_sel_q][wr_idx_q*DATA_WIDTH +: DATA_WIDTH] <= rom_data;
      if (state_q == ST_SWAP) begin
        bank_sel_q  <= ~bank_sel_q;
        act_stage_q <= stage_q;
        ready_q     <= 1'b1;
      end
    end
  end

  assign o_busy  = busy_q;
  assign o_ready = ready_q;
  assign o_done  = done_q;
  assign o_error = error_q;
  assign o_stage = act_stage_q;
  assign o_rom   = bank_q[bank_sel_q];

endmodule

// File: tb/tb_multi_stage_database_loader.sv
// tb/tb_multi_stage_database_loader.sv - randomized bench against a request-queue reference model
module tb_multi_stage_database_loader;

  localparam int NS = 3;
  localparam int N  = 7;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int SW = 2;
  localparam int RW = N * DW;
  localparam int LAT = N + 3;

  logic          clk_fpga = 1'b0;
  logic          reset_fpga = 1'b1;
  logic          i_load = 1'b0;
  logic          i_abort = 1'b0;
  logic [SW-1:0] i_stage = '0;
  logic          o_busy, o_ready, o_done, o_error;
  logic [SW-1:0] o_stage;
  logic [RW-1:0] o_rom;

  multi_stage_database_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_STAGES(NS), .NUM_CLASSIFIERS(2),
    .NUM_PARAM_PER_CLASSIFIER(3), .NUM_STAGE_THRESHOLD(1), .FILE_STAGE_MEM("")
  ) dut (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga), .i_load(i_load), .i_stage(i_stage),
    .i_abort(i_abort), .o_busy(o_busy), .o_ready(o_ready), .o_done(o_done),
    .o_error(o_error), .o_stage(o_stage), .o_rom(o_rom)
  );

  always #5 clk_fpga = ~clk_fpga;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int due_q[$];
  int stg_q[$];
  int exp_stage = 0;
  bit exp_ready = 1'b0;
  int err_due = -1;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] img(input int s);
    logic [RW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'(16'h0100 + s * N + k);
    return r;
  endfunction

  task automatic step();
    bit d;
    @(negedge clk_fpga);
    cyc++;
    d = (due_q.size() > 0) && (due_q[0] == cyc);
    if (d) begin
      exp_stage = stg_q.pop_front();
      void'(due_q.pop_front());
      exp_ready = 1'b1;
    end
    check("done", RW'(o_done), RW'(d));
    check("error", RW'(o_error), RW'(err_due == cyc));
    check("busy", RW'(o_busy), RW'(due_q.size() > 0));
    check("ready", RW'(o_ready), RW'(exp_ready));
    check("stage", RW'(o_stage), RW'(exp_stage));
    check("rom", o_rom, exp_ready ? img(exp_stage) : '0);
  endtask

  // A request is taken when nothing is pending or the pending load is in its swap cycle.
  task automatic tick(input bit l, input int s, input bit a);
    bit accepting;
    i_load    = l;
    i_stage   = SW'(s);
    i_abort   = a;
    accepting = (due_q.size() == 0) || (due_q[0] == cyc + 1);
    if (l && !a && accepting) begin
      if (s < NS) begin
        due_q.push_back(cyc + LAT);
        stg_q.push_back(s);
      end else begin
        err_due = cyc + 1;
      end
    end
    if (a && due_q.size() > 0 && due_q[0] > cyc + 1) begin
      due_q.delete();
      stg_q.delete();
    end
    step();
    i_load  = 1'b0;
    i_abort = 1'b0;
  endtask

  task automatic run(input int s, input bit a0, input int j, input bit jl, input int s2,
                     input bit ja, input int len);
    tick(1'b1, s, a0);
    for (int i = 1; i <= len; i++) begin
      if (i == j) tick(jl, s2, ja);
      else        tick(1'b0, 0, 1'b0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rom"}, o_rom, '0);
    check({tag, "_stage"}, RW'(o_stage), '0);
    check({tag, "_ready"}, RW'(o_ready), '0);
    check({tag, "_busy"}, RW'(o_busy), '0);
    check({tag, "_done"}, RW'(o_done), '0);
    check({tag, "_error"}, RW'(o_error), '0);
  endtask

  initial begin
    repeat (3) @(negedge clk_fpga);
    check_zero("rst");
    reset_fpga = 1'b0;
    repeat (2) tick(1'b0, 0, 1'b0);

    run(1, 1'b0, 0, 1'b0, 0, 1'b0, 12);
    run(0, 1'b0, 0, 1'b0, 0, 1'b0, 12);
    run(2, 1'b0, 4, 1'b0, 0, 1'b1, 14);
    run(0, 1'b0, 0, 1'b0, 0, 1'b0, 12);
    run(3, 1'b0, 0, 1'b0, 0, 1'b0, 4);
    run(1, 1'b0, 3, 1'b1, 2, 1'b0, 14);
    run(2, 1'b0, 9, 1'b1, 0, 1'b0, 22);
    run(1, 1'b0, 9, 1'b1, 2, 1'b1, 14);
    run(2, 1'b1, 0, 1'b0, 0, 1'b0, 4);
    run(2, 1'b0, 9, 1'b1, 3, 1'b0, 12);

    tick(1'b1, 1, 1'b0);
    repeat (2) tick(1'b0, 0, 1'b0);
    #2 reset_fpga = 1'b1;
    #1 check_zero("async_rst");
    due_q.delete();
    stg_q.delete();
    exp_ready = 1'b0;
    exp_stage = 0;
    err_due   = -1;
    @(negedge clk_fpga);
    cyc++;
    reset_fpga = 1'b0;
    run(2, 1'b0, 0, 1'b0, 0, 1'b0, 12);

    for (int r = 0; r < 12; r++) begin
      run($urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom_range(0, 10),
          1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 2) == 0), 22);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
